// File: rtl/ddr2_cmd_fifo.sv
// Host-side command/write-data FIFO for the DDR2 front end, with FWFT read and advisory notfull.
// Optional sticky overflow flag is built only when DDR2_CMD_FIFO_OVF_EN is defined.
module ddr2_cmd_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int CNT_W       = 7,
  parameter int FULL_THRESH = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              notfull,
  output logic [CNT_W-1:0]  fillcount,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  input  logic              pop,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              pop_acc;
  logic              push_acc;

  // Acceptance: a pop frees a slot in the same cycle, so a full FIFO can take push & pop together.
  always_comb begin
    pop_acc  = pop & (fill_q != {CNT_W{1'b0}});
    push_acc = push & ((fill_q < CNT_W'(DEPTH)) | pop_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_acc, pop_acc})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and fill-count state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      fill_q   <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is deliberately left unreset; dout is only meaningful while valid.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign fillcount = fill_q;
  assign notfull   = (fill_q < CNT_W'(FULL_THRESH));
  assign valid     = (fill_q != {CNT_W{1'b0}});
  assign dout      = mem_q[rd_ptr_q];

`ifdef DDR2_CMD_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (push & ~push_acc);
  end

  // Sticky overflow: set by any rejected push, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (push && !push_acc) begin
        $display("ddr2_cmd_fifo overflow at time %0t fillcount %0d", $time, fill_q);
      end
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_cmd_fifo.sv
// Scoreboard bench for ddr2_cmd_fifo: stimulus queues expected words, a negedge monitor checks dout on each pop.
module tb_ddr2_cmd_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [31:0] din;
  logic        notfull;
  logic [6:0]  fillcount;
  logic        valid;
  logic [31:0] dout;
  logic        pop;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  logic ovf_m = 1'b0;
  logic [31:0] exp_q [$];

  ddr2_cmd_fifo dut (
    .clk(clk), .reset(reset), .push(push), .din(din), .notfull(notfull),
    .fillcount(fillcount), .valid(valid), .dout(dout), .pop(pop), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: whenever the scheduler side pops a valid word, it must be the oldest queued one.
  always @(negedge clk) begin
    if (!reset && pop && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_unexpected actual=0x%08h expected=<none>", dout);
      end else begin
        chk("dout_order", dout, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic p, input logic [31:0] d, input logic q);
    logic pa, wa;
    push = p; din = d; pop = q;
    pa = q && (mcnt != 0);
    wa = p && ((mcnt < 64) || pa);
    if (wa) exp_q.push_back(d);
    if (p && !wa) ovf_m = 1'b1;
    @(posedge clk); #1;
    if (wa && !pa) mcnt++;
    else if (pa && !wa) mcnt--;
    push = 1'b0; pop = 1'b0;
    chk("fillcount", {25'd0, fillcount}, mcnt);
    chk("notfull", {31'd0, notfull}, {31'd0, (mcnt < 33)});
    chk("valid", {31'd0, valid}, {31'd0, (mcnt != 0)});
`ifdef DDR2_CMD_FIFO_OVF_EN
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
`else
    chk("overflow", {31'd0, overflow}, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; din = 32'd0;
    #12;
    chk("rst_fillcount", {25'd0, fillcount}, 32'd0);
    chk("rst_notfull", {31'd0, notfull}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single push, then drain it.
    step(1'b1, 32'hA5A5_0001, 1'b0);
    chk("t1_fillcount", {25'd0, fillcount}, 32'd1);
    chk("t1_dout", dout, 32'hA5A5_0001);
    chk("t1_valid", {31'd0, valid}, 32'd1);
    step(1'b0, 32'd0, 1'b1);

    // Empty with push & pop: pop ignored, push accepted.
    step(1'b1, 32'hBEEF_0000, 1'b1);
    chk("empty_pp_fill", {25'd0, fillcount}, 32'd1);
    chk("empty_pp_dout", dout, 32'hBEEF_0000);
    step(1'b0, 32'd0, 1'b1);

    // Fill 0 -> 64, watching the 32/33 notfull edge.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 32'h100 + i, 1'b0);
      if (i == 31) chk("fill32_notfull", {31'd0, notfull}, 32'd1);
      if (i == 32) chk("fill33_notfull", {31'd0, notfull}, 32'd0);
    end
    chk("full_fill", {25'd0, fillcount}, 32'd64);

    // Push only at full: rejected.
    step(1'b1, 32'hDEAD_DEAD, 1'b0);
    chk("reject_fill", {25'd0, fillcount}, 32'd64);
`ifdef DDR2_CMD_FIFO_OVF_EN
    chk("reject_ovf", {31'd0, overflow}, 32'd1);
`endif

    // Full with push & pop for 10 cycles: dout walks 0x100..0x109.
    for (int i = 0; i < 10; i++) begin
      if (i < 3) chk("full_pp_head", dout, 32'h100 + i);
      step(1'b1, 32'h200 + i, 1'b1);
    end
    chk("full_pp_fill", {25'd0, fillcount}, 32'd64);

    // Drain to 5, watching the 33 -> 32 notfull edge.
    for (int i = 0; i < 59; i++) begin
      step(1'b0, 32'd0, 1'b1);
      if (fillcount == 7'd33) chk("drain33_notfull", {31'd0, notfull}, 32'd0);
      if (fillcount == 7'd32) chk("drain32_notfull", {31'd0, notfull}, 32'd1);
    end
    chk("drain_fill", {25'd0, fillcount}, 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);

    // Pointer wrap: preload 0..4, then 100 push/pop pairs; pops yield 0..99.
    for (int i = 0; i < 5; i++) step(1'b1, i, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (i == 0 || i == 63 || i == 99) chk("wrap_head", dout, i);
      step(1'b1, 32'd5 + i, 1'b1);
    end
    chk("wrap_fill", {25'd0, fillcount}, 32'd5);

    // Async reset at fillcount 40, mid-cycle.
    while (mcnt < 40) step(1'b1, 32'h300 + mcnt, 1'b0);
    chk("pre_rst_fill", {25'd0, fillcount}, 32'd40);
    #2 reset = 1'b1;
    #1;
    chk("arst_fillcount", {25'd0, fillcount}, 32'd0);
    chk("arst_notfull", {31'd0, notfull}, 32'd1);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    mcnt = 0;
    ovf_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 32'hCAFE_0001, 1'b0);
    chk("post_rst_dout", dout, 32'hCAFE_0001);
    step(1'b0, 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
